host_reg_file: RTL

Host-visible control/status register file sitting directly upstream of the vector-add compute engine.
- Host side: accepts read/write requests over the TSIM host request/response channel.
- Compute side: drives launch, length and the a/b/c base addresses; captures finish and the cycle-count event.
- Sole point through which the host starts a job and polls for completion.

---
 rtl/host_reg_file_pkg.sv | 21 ++
 rtl/host_reg_file_if.sv | 24 ++
 rtl/host_reg_file.sv | 105 ++++++++++
 3 files changed

// File: rtl/host_reg_file_pkg.sv
// Shared types and register map for the host-facing control/status register file.
// Byte offsets match the host driver's view of the vector-add engine.
package host_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam int REG_CTRL   = 'h00;
    localparam int REG_CYCLES = 'h04;
    localparam int REG_LENGTH = 'h08;
    localparam int REG_A_ADDR = 'h0C;
    localparam int REG_B_ADDR = 'h10;
    localparam int REG_C_ADDR = 'h14;

    localparam int CTRL_LAUNCH = 0;
    localparam int CTRL_FINISH = 1;

endpackage

// File: rtl/host_reg_file_if.sv
// Host request/response channel: request held stable until deq, read data returned with deq.
// The host side is the master; the register file is the slave.
interface host_reg_file_if #(
    parameter int HOST_ADDR_BITS = 8,
    parameter int HOST_DATA_BITS = 32
);
    logic                      req_valid;
    logic                      req_opcode;
    logic [HOST_ADDR_BITS-1:0] req_addr;
    logic [HOST_DATA_BITS-1:0] req_value;
    logic                      req_deq;
    logic                      resp_valid;
    logic [HOST_DATA_BITS-1:0] resp_bits;

    modport master (
        output req_valid, req_opcode, req_addr, req_value,
        input  req_deq, resp_valid, resp_bits
    );

    modport slave (
        input  req_valid, req_opcode, req_addr, req_value,
        output req_deq, resp_valid, resp_bits
    );
endinterface

// File: rtl/host_reg_file.sv
// Control/status registers between the host and the vector-add engine; one request per two cycles,
// deq (and read data) one cycle after the request is seen. Compute-side outputs come straight from flops.
module host_reg_file
    import host_pkg::*;
#(
    parameter int HOST_ADDR_BITS = 8,
    parameter int HOST_DATA_BITS = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    host_reg_file_if.slave            host,
    output logic                      launch,
    input  logic                      finish,
    input  logic                      event_counter_valid,
    input  logic [HOST_DATA_BITS-1:0] event_counter_value,
    output logic [HOST_DATA_BITS-1:0] length,
    output logic [HOST_DATA_BITS-1:0] a_addr,
    output logic [HOST_DATA_BITS-1:0] b_addr,
    output logic [HOST_DATA_BITS-1:0] c_addr
);

    state_t                    state;
    state_t                    state_nxt;
    logic                      finish_bit;
    logic [HOST_DATA_BITS-1:0] cycles;
    logic [HOST_DATA_BITS-1:0] rdata;

    logic hit_ctrl, hit_cycles, hit_length, hit_a, hit_b, hit_c;
    logic wr;

    assign hit_ctrl   = (host.req_addr == HOST_ADDR_BITS'(REG_CTRL));
    assign hit_cycles = (host.req_addr == HOST_ADDR_BITS'(REG_CYCLES));
    assign hit_length = (host.req_addr == HOST_ADDR_BITS'(REG_LENGTH));
    assign hit_a      = (host.req_addr == HOST_ADDR_BITS'(REG_A_ADDR));
    assign hit_b      = (host.req_addr == HOST_ADDR_BITS'(REG_B_ADDR));
    assign hit_c      = (host.req_addr == HOST_ADDR_BITS'(REG_C_ADDR));

    assign wr = (state == WRITE);

    always_comb begin
        state_nxt = IDLE;
        if (state == IDLE && host.req_valid) begin
            state_nxt = host.req_opcode ? WRITE : READ;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            launch     <= 1'b0;
            finish_bit <= 1'b0;
            cycles     <= '0;
            length     <= '0;
            a_addr     <= '0;
            b_addr     <= '0;
            c_addr     <= '0;
        end else begin
            state <= state_nxt;

            // Job completion beats a simultaneous host CTRL write.
            if (finish) begin
                launch     <= 1'b0;
                finish_bit <= 1'b1;
            end else if (wr && hit_ctrl) begin
                launch     <= host.req_value[CTRL_LAUNCH];
                finish_bit <= 1'b0;
            end

            if (event_counter_valid) begin
                cycles <= event_counter_value;
            end

            // Job parameters are frozen while the engine is running.
            if (wr && !launch) begin
                if (hit_length) length <= host.req_value;
                if (hit_a)      a_addr <= host.req_value;
                if (hit_b)      b_addr <= host.req_value;
                if (hit_c)      c_addr <= host.req_value;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (hit_ctrl) begin
            rdata[CTRL_LAUNCH] = launch;
            rdata[CTRL_FINISH] = finish_bit;
        end else if (hit_cycles) begin
            rdata = cycles;
        end else if (hit_length) begin
            rdata = length;
        end else if (hit_a) begin
            rdata = a_addr;
        end else if (hit_b) begin
            rdata = b_addr;
        end else if (hit_c) begin
            rdata = c_addr;
        end
    end

    assign host.req_deq    = (state == READ) || (state == WRITE);
    assign host.resp_valid = (state == READ);
    assign host.resp_bits  = (state == READ) ? rdata : '0;

endmodule
